// File: rtl/register_write_queue_if.sv
// Bundle between a result producer, the write queue and the register file write port.
// The queue side uses the slave modport; the producer/register-file side uses master.
interface register_write_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
);
  logic                        result_valid;
  logic                        result_ready;
  logic [ADDR_WIDTH-1:0]       result_register;
  logic [DATA_WIDTH-1:0]       result_data;
  logic                        flush;
  logic                        write_stall;
  logic [ADDR_WIDTH-1:0]       write_register;
  logic [DATA_WIDTH-1:0]       write_data;
  logic                        write_enable;
  logic [(2**ADDR_WIDTH)-1:0]  pending;
  logic [$clog2(DEPTH):0]      occupancy;

  modport master (
    output result_valid, result_register, result_data, flush, write_stall,
    input  result_ready, write_register, write_data, write_enable, pending, occupancy
  );

  modport slave (
    input  result_valid, result_register, result_data, flush, write_stall,
    output result_ready, write_register, write_data, write_enable, pending, occupancy
  );
endinterface

// File: rtl/register_write_queue.sv
// In-order write buffer in front of the register file write port, with a per-register
// pending mask for read-after-write hazard detection.
module register_write_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  register_write_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int NREG  = 2 ** ADDR_WIDTH;

  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [OCC_W-1:0]      occ_r;
  logic [DEPTH-1:0]      valid_r;
  logic [ADDR_WIDTH-1:0] reg_r  [DEPTH];
  logic [DATA_WIDTH-1:0] data_r [DEPTH];
  logic [NREG-1:0]       pending_r;

  logic                  not_empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [OCC_W-1:0]      occ_next_s;
  logic [DEPTH-1:0]      valid_next_s;
  logic [NREG-1:0]       pending_next_s;

  function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] idx);
    reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Handshake and pop qualification; ready depends only on registered occupancy.
  always_comb begin
    not_empty_s = (occ_r != {OCC_W{1'b0}});
    full_s      = (occ_r == OCC_W'(DEPTH));
    push_s      = bus.result_valid & ~full_s & ~bus.flush;
    pop_s       = not_empty_s & ~bus.write_stall & ~bus.flush;
  end

  // Next occupancy, entry-valid vector and pending mask as they will be after this edge.
  always_comb begin
    occ_next_s     = occ_r;
    valid_next_s   = valid_r;
    pending_next_s = {NREG{1'b0}};
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
      2'b01:   occ_next_s = occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
      default: occ_next_s = occ_r;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      // A slot is never pushed and popped in the same cycle, so the push test may win.
      if (bus.flush) begin
        valid_next_s[i] = 1'b0;
      end else if (push_s && (tail_r == PTR_W'(i))) begin
        valid_next_s[i] = 1'b1;
      end else if (pop_s && (head_r == PTR_W'(i))) begin
        valid_next_s[i] = 1'b0;
      end else begin
        valid_next_s[i] = valid_r[i];
      end
      if (valid_next_s[i]) begin
        pending_next_s = pending_next_s | reg_onehot(
          (push_s && (tail_r == PTR_W'(i))) ? bus.result_register : reg_r[i]);
      end else begin
        pending_next_s = pending_next_s;
      end
    end
  end

  // Queue storage, pointers, occupancy and pending mask.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      valid_r   <= {DEPTH{1'b0}};
      pending_r <= {NREG{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        reg_r[i]  <= {ADDR_WIDTH{1'b0}};
        data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      valid_r   <= valid_next_s;
      pending_r <= pending_next_s;
      if (bus.flush) begin
        head_r <= {PTR_W{1'b0}};
        tail_r <= {PTR_W{1'b0}};
        occ_r  <= {OCC_W{1'b0}};
      end else begin
        occ_r <= occ_next_s;
        if (push_s) begin
          reg_r[tail_r]  <= bus.result_register;
          data_r[tail_r] <= bus.result_data;
          tail_r         <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        if (pop_s) begin
          head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Register file port shows the head entry only while something is queued.
  always_comb begin
    bus.result_ready   = ~full_s;
    bus.write_enable   = pop_s;
    bus.pending        = pending_r;
    bus.occupancy      = occ_r;
    if (not_empty_s) begin
      bus.write_register = reg_r[head_r];
      bus.write_data     = data_r[head_r];
    end else begin
      bus.write_register = {ADDR_WIDTH{1'b0}};
      bus.write_data     = {DATA_WIDTH{1'b0}};
    end
  end
endmodule

// File: tb/tb_register_write_queue.sv
// Directed bench for register_write_queue: accepted pushes feed an expected-write queue,
// a negedge monitor pops and compares every write the DUT issues.
module tb_register_write_queue;
  typedef struct packed {
    logic [1:0]  r;
    logic [31:0] d;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   wr_mark = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [31:0] reg_file [4];

  register_write_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .DEPTH(4)) bus ();

  register_write_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .DEPTH(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && bus.occupancy != 0; i++) tick();
    check("drain_occupancy", bus.occupancy, 0);
  endtask

  // Scoreboard producer: a push is recorded at the edge where the handshake completes.
  always @(posedge clock) begin
    if (reset_n && bus.result_valid && bus.result_ready && !bus.flush)
      exp_q.push_back('{r: bus.result_register, d: bus.result_data});
    if (reset_n && bus.flush)
      exp_q.delete();
  end

  always @(negedge reset_n) exp_q.delete();

  // Scoreboard consumer: every issued write must match the oldest expected one.
  always @(negedge clock) begin
    if (reset_n && bus.write_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=r%0d/%0h expected=none",
                 bus.write_register, bus.write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_write_register", bus.write_register, mon_e.r);
        check("sb_write_data", bus.write_data, mon_e.d);
      end
      reg_file[bus.write_register] = bus.write_data;
      wr_count++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.result_valid = 1'b0;
    bus.result_register = 2'd0;
    bus.result_data = 32'd0;
    bus.flush = 1'b0;
    bus.write_stall = 1'b0;
    for (int i = 0; i < 4; i++) reg_file[i] = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", bus.result_ready, 1);
    check("rst_we", bus.write_enable, 0);
    check("rst_wreg", bus.write_register, 0);
    check("rst_wdata", bus.write_data, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_occ", bus.occupancy, 0);
    reset_n = 1'b1;

    // 1: single write, one-cycle latency
    bus.result_valid = 1'b1; bus.result_register = 2'd2; bus.result_data = 32'hDEADBEEF;
    tick();
    bus.result_valid = 1'b0;
    at_neg();
    check("t1_we", bus.write_enable, 1);
    check("t1_wreg", bus.write_register, 2);
    check("t1_wdata", bus.write_data, 32'hDEADBEEF);
    check("t1_pending", bus.pending, 4'b0100);
    check("t1_occ", bus.occupancy, 1);
    tick();
    at_neg();
    check("t1_pending_clr", bus.pending, 0);
    check("t1_occ_clr", bus.occupancy, 0);
    check("t1_we_clr", bus.write_enable, 0);

    // 2: fill under stall, then drain in order
    bus.write_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.result_valid = 1'b1; bus.result_register = 2'(i); bus.result_data = 32'h10 + 32'(i);
      tick();
    end
    bus.result_valid = 1'b0;
    at_neg();
    check("t2_ready_full", bus.result_ready, 0);
    check("t2_occ_full", bus.occupancy, 4);
    check("t2_pending_all", bus.pending, 4'b1111);
    check("t2_we_stalled", bus.write_enable, 0);
    tick();
    at_neg();
    check("t2_head_stable", bus.write_data, 32'h10);
    bus.write_stall = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t2_we_burst", bus.write_enable, 1);
      check("t2_order_reg", bus.write_register, k);
      @(posedge clock);
      @(negedge clock);
      #1;
    end
    check("t2_occ_empty", bus.occupancy, 0);
    check("t2_we_done", bus.write_enable, 0);

    // 3: push offered to a full queue while a pop happens
    tick();
    bus.write_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.result_valid = 1'b1; bus.result_register = 2'(i); bus.result_data = 32'h20 + 32'(i);
      tick();
    end
    wr_mark = wr_count;
    bus.result_register = 2'd2; bus.result_data = 32'h30; bus.write_stall = 1'b0;
    at_neg();
    check("t3_ready_full", bus.result_ready, 0);
    check("t3_we_full", bus.write_enable, 1);
    tick();
    at_neg();
    check("t3_occ_after_pop", bus.occupancy, 3);
    check("t3_ready_again", bus.result_ready, 1);
    tick();
    bus.result_valid = 1'b0;
    at_neg();
    check("t3_occ_push_pop", bus.occupancy, 3);
    drain();
    check("t3_write_count", wr_count - wr_mark, 5);
    check("t3_sb_empty", exp_q.size(), 0);

    // 4: two writes to the same register
    bus.write_stall = 1'b1;
    bus.result_valid = 1'b1; bus.result_register = 2'd1; bus.result_data = 32'hA;
    tick();
    bus.result_data = 32'hB;
    tick();
    bus.result_valid = 1'b0; bus.write_stall = 1'b0;
    at_neg();
    check("t4_pending_first", bus.pending, 4'b0010);
    check("t4_wdata_first", bus.write_data, 32'hA);
    tick();
    at_neg();
    check("t4_pending_hold", bus.pending, 4'b0010);
    check("t4_wdata_second", bus.write_data, 32'hB);
    tick();
    at_neg();
    check("t4_pending_clr", bus.pending, 0);
    check("t4_regfile_r1", reg_file[1], 32'hB);

    // 5: flush with a push offered in the same cycle
    tick();
    bus.write_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.result_valid = 1'b1; bus.result_register = 2'(i); bus.result_data = 32'h50 + 32'(i);
      tick();
    end
    wr_mark = wr_count;
    bus.result_register = 2'd3; bus.result_data = 32'h99;
    bus.flush = 1'b1; bus.write_stall = 1'b0;
    at_neg();
    check("t5_we_flush", bus.write_enable, 0);
    check("t5_ready_flush", bus.result_ready, 1);
    check("t5_occ_pre", bus.occupancy, 3);
    tick();
    bus.flush = 1'b0; bus.result_valid = 1'b0;
    at_neg();
    check("t5_occ_post", bus.occupancy, 0);
    check("t5_pending_post", bus.pending, 0);
    check("t5_we_post", bus.write_enable, 0);
    repeat (3) tick();
    check("t5_no_writes", wr_count - wr_mark, 0);

    // 6: asynchronous reset between edges
    bus.write_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.result_valid = 1'b1; bus.result_register = 2'(i); bus.result_data = 32'h60 + 32'(i);
      tick();
    end
    bus.result_valid = 1'b0; bus.write_stall = 1'b0;
    #2;
    check("t6_we_before", bus.write_enable, 1);
    reset_n = 1'b0;
    #1;
    check("t6_we_async", bus.write_enable, 0);
    check("t6_pending_async", bus.pending, 0);
    check("t6_occ_async", bus.occupancy, 0);
    check("t6_ready_async", bus.result_ready, 1);
    tick();
    reset_n = 1'b1;
    bus.result_valid = 1'b1; bus.result_register = 2'd3; bus.result_data = 32'h77;
    tick();
    bus.result_valid = 1'b0;
    at_neg();
    check("t6_we_after", bus.write_enable, 1);
    check("t6_pending_after", bus.pending, 4'b1000);
    drain();
    check("t6_regfile_r3", reg_file[3], 32'h77);
    check("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
